decoder_n_scan: RTL and testbench
=================================

DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 Parameter N, default 3, select-address width; output width is 2**N.
REQ-002 Parameter DWELL_W, default 4, width of scan dwell count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 E  input  1  enable; low forces idle.
REQ-006 A  input  N  select address (DECODE) / scan start address (SCAN, load).
REQ-007 mode  input  1  0 = DECODE, 1 = SCAN.
REQ-008 load  input  1  SCAN only: reload scan index from A.
REQ-009 dwell  input  DWELL_W  cycles each SCAN position is held, minus one.
REQ-010 Y  output  2**N  registered one-hot output, all-zero when idle.
REQ-011 idx  output  N  registered index of the active Y bit.
REQ-012 wrap  output  1  one-cycle pulse when the scan index wraps 2**N-1 -> 0.

Function
REQ-013 FSM states SHALL be IDLE, DECODE, SCAN; all outputs registered.
REQ-014 Y SHALL equal one-hot(idx) in DECODE/SCAN and all-zero in IDLE.
REQ-015 IDLE: E=1,mode=0 -> DECODE; E=1,mode=1 -> SCAN with idx<=A, dwell counter<=0.
REQ-016 DECODE: each cycle idx<=A; Y reflects A with exactly one cycle latency.
REQ-017 SCAN: idx SHALL be held for dwell+1 cycles, then increment by 1; dwell=0 advances every cycle.
REQ-018 dwell SHALL be compared live against the internal counter; counter clears on every advance.
REQ-019 SCAN advance from idx=2**N-1 SHALL wrap to 0 and assert wrap for exactly the cycle idx=0 is first presented.
REQ-020 load=1 in SCAN SHALL set idx<=A, clear dwell counter; load has priority over advance; wrap not asserted on load.
REQ-021 load SHALL be ignored in IDLE and DECODE.
REQ-022 E=0 in any state -> IDLE next cycle: Y=0, wrap=0, idx holds last value, dwell counter cleared.
REQ-023 mode 0->1 with E=1: next state SCAN, idx<=A, counter<=0; mode 1->0: next state DECODE, idx<=A.
REQ-024 At most one Y bit SHALL be high in any cycle.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 rst=1 SHALL force state IDLE, Y=0, idx=0, wrap=0, dwell counter=0 on next edge.
REQ-027 rst SHALL take priority over E, mode, load; mid-scan reset discards scan position.
REQ-028 First cycle after rst deasserts follows REQ-015 from IDLE.

Structure
REQ-029 Package decoder_pkg SHALL hold the state enumeration and MODE_DECODE/MODE_SCAN constants.
REQ-030 One combinational sub-module decoder_onehot (N in, 2**N one-hot out, enable) SHALL generate Y's next value.
REQ-031 Expected size 120-400 lines RTL including FSM, counter, sub-module.

Verification
REQ-032 N=3, E=1, mode=0, A=5 -> next cycle Y=8'b0010_0000, idx=5; A=0 -> Y=8'b0000_0001 one cycle later.
REQ-033 N=3, mode=1, A=6, dwell=0 -> idx 6,7,0,1 on successive cycles; wrap=1 only with idx=0.
REQ-034 mode=1, A=2, dwell=2 -> idx=2 for 3 cycles, then 3 for 3 cycles.
REQ-035 SCAN at idx=7 with counter expiring, load=1, A=4 same cycle -> idx=4, wrap=0.
REQ-036 SCAN idx=3, rst=1 one cycle -> Y=0, idx=0, wrap=0; E=0 during SCAN -> Y=0 next cycle, idx held.
REQ-037 Random stimulus all modes -> assertion: $onehot0(Y) every cycle, Y==one-hot(idx) whenever not IDLE.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared FSM state encoding and mode constants for the one-hot decoder/scanner.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SCAN
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2**N one-hot decoder; all-zero when disabled.
module decoder_onehot #(
  parameter int N = 3
) (
  input  logic          en_i,
  input  logic [N-1:0]  sel_i,
  output logic [2**N-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered one-hot decoder with a SCAN mode that steps the active bit,
// holding each position for dwell+1 cycles and pulsing wrap on 2**N-1 -> 0.
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               E,
  input  logic [N-1:0]       A,
  input  logic               mode,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    Y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam logic [N-1:0] IDX_MAX = '1;

  state_e             state_q, state_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [2**N-1:0]    y_q, y_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!E) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (mode == MODE_DECODE) begin
      state_d = ST_DECODE;
      idx_d   = A;
      cnt_d   = '0;
    end else if (state_q != ST_SCAN) begin
      state_d = ST_SCAN;
      idx_d   = A;
      cnt_d   = '0;
    end else if (load) begin
      idx_d = A;
      cnt_d = '0;
    end else if (cnt_q == dwell) begin
      // dwell is compared live, so a change takes effect on the current hold
      idx_d  = idx_q + N'(1);
      cnt_d  = '0;
      wrap_d = (idx_q == IDX_MAX);
    end else begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  // Y is decoded from the next index so it lands in the same cycle as idx
  decoder_onehot #(
    .N(N)
  ) u_onehot (
    .en_i  (state_d != ST_IDLE),
    .sel_i (idx_d),
    .y_o   (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Directed and random checks of decoder_n_scan against a queued scoreboard.
module tb_decoder_n_scan;

  localparam int N  = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          E = 1'b0;
  logic          mode = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  A = '0;
  logic [DW-1:0] dwell = '0;
  logic [7:0]    Y;
  logic [N-1:0]  idx;
  logic          wrap;

  always #5 clk = ~clk;

  decoder_n_scan #(
    .N(N),
    .DWELL_W(DW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .E     (E),
    .A     (A),
    .mode  (mode),
    .load  (load),
    .dwell (dwell),
    .Y     (Y),
    .idx   (idx),
    .wrap  (wrap)
  );

  typedef struct {
    string        tag;
    logic         act;
    logic [N-1:0] idx;
    logic         wrap;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  // random-phase reference: 0 idle, 1 decode, 2 scan
  int           m_st  = 0;
  logic [N-1:0] m_idx = '0;
  int           m_cnt = 0;
  logic         m_wrap = 1'b0;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e,
                      input logic m, input logic l, input logic [N-1:0] a,
                      input logic [DW-1:0] d, input logic xact,
                      input logic [N-1:0] xidx, input logic xwrap);
    exp_t x;
    logic [7:0] xy;
    rst = r; E = e; mode = m; load = l; A = a; dwell = d;
    sb.push_back('{tag, xact, xidx, xwrap});
    @(posedge clk);
    #1;
    x  = sb.pop_front();
    xy = 8'd0;
    if (x.act) xy = 8'd1 << x.idx;
    chk(x.tag, "Y",    {24'd0, Y},   {24'd0, xy});
    chk(x.tag, "idx",  {29'd0, idx}, {29'd0, x.idx});
    chk(x.tag, "wrap", {31'd0, wrap}, {31'd0, x.wrap});
    chk(x.tag, "onehot0", {31'd0, $onehot0(Y)}, 32'd1);
  endtask

  task automatic rand_step();
    logic r, e, m, l;
    logic [N-1:0] a;
    logic [DW-1:0] d;
    r = ($urandom_range(0, 31) == 0);
    e = ($urandom_range(0, 7) != 0);
    m = ($urandom_range(0, 2) != 0);
    l = ($urandom_range(0, 5) == 0);
    a = N'($urandom_range(0, 7));
    d = DW'($urandom_range(0, 2));
    m_wrap = 1'b0;
    if (r) begin
      m_st = 0; m_idx = '0; m_cnt = 0;
    end else if (!e) begin
      m_st = 0; m_cnt = 0;
    end else if (!m) begin
      m_st = 1; m_idx = a; m_cnt = 0;
    end else if (m_st != 2) begin
      m_st = 2; m_idx = a; m_cnt = 0;
    end else if (l) begin
      m_idx = a; m_cnt = 0;
    end else if (m_cnt == int'(d)) begin
      m_wrap = (m_idx == 3'd7);
      m_idx  = (m_idx == 3'd7) ? 3'd0 : m_idx + 3'd1;
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    step("rand", r, e, m, l, a, d, (m_st != 0), m_idx, m_wrap);
  endtask

  initial begin
    step("rst0",      1, 0, 0, 0, 3'd0, 4'd0, 0, 3'd0, 0);
    step("rst_prio",  1, 1, 1, 1, 3'd5, 4'd0, 0, 3'd0, 0);
    step("dec_a5",    0, 1, 0, 0, 3'd5, 4'd0, 1, 3'd5, 0);
    step("dec_a0",    0, 1, 0, 0, 3'd0, 4'd0, 1, 3'd0, 0);
    step("dec_load",  0, 1, 0, 1, 3'd3, 4'd0, 1, 3'd3, 0);
    step("scan6",     0, 1, 1, 0, 3'd6, 4'd0, 1, 3'd6, 0);
    step("scan7",     0, 1, 1, 0, 3'd2, 4'd0, 1, 3'd7, 0);
    step("scan0w",    0, 1, 1, 0, 3'd2, 4'd0, 1, 3'd0, 1);
    step("scan1",     0, 1, 1, 0, 3'd2, 4'd0, 1, 3'd1, 0);
    step("e_off",     0, 0, 1, 0, 3'd5, 4'd0, 0, 3'd1, 0);
    step("idle_load", 0, 0, 1, 1, 3'd6, 4'd0, 0, 3'd1, 0);
    step("dw2_a",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd2, 0);
    step("dw2_b",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd2, 0);
    step("dw2_c",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd2, 0);
    step("dw2_d",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd3, 0);
    step("dw2_e",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd3, 0);
    step("dw2_f",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd3, 0);
    step("dw2_g",     0, 1, 1, 0, 3'd2, 4'd2, 1, 3'd4, 0);
    step("ld7",       0, 1, 1, 1, 3'd7, 4'd0, 1, 3'd7, 0);
    step("ld_prio",   0, 1, 1, 1, 3'd4, 4'd0, 1, 3'd4, 0);
    step("adv5",      0, 1, 1, 0, 3'd0, 4'd0, 1, 3'd5, 0);
    step("ld7b",      0, 1, 1, 1, 3'd7, 4'd1, 1, 3'd7, 0);
    step("hold7",     0, 1, 1, 0, 3'd0, 4'd1, 1, 3'd7, 0);
    step("wrap_dw1",  0, 1, 1, 0, 3'd0, 4'd1, 1, 3'd0, 1);
    step("hold0",     0, 1, 1, 0, 3'd0, 4'd1, 1, 3'd0, 0);
    step("adv1",      0, 1, 1, 0, 3'd0, 4'd1, 1, 3'd1, 0);
    step("ld3",       0, 1, 1, 1, 3'd3, 4'd0, 1, 3'd3, 0);
    step("rst_scan",  1, 1, 1, 0, 3'd0, 4'd0, 0, 3'd0, 0);
    step("post_rst",  0, 1, 1, 0, 3'd1, 4'd0, 1, 3'd1, 0);
    step("mode10",    0, 1, 0, 0, 3'd6, 4'd0, 1, 3'd6, 0);
    step("mode01",    0, 1, 1, 0, 3'd2, 4'd3, 1, 3'd2, 0);
    step("live_dw",   0, 1, 1, 0, 3'd0, 4'd0, 1, 3'd3, 0);
    step("dec4",      0, 1, 0, 0, 3'd4, 4'd0, 1, 3'd4, 0);
    step("dec_off",   0, 0, 0, 0, 3'd1, 4'd0, 0, 3'd4, 0);
    step("idle_scan", 0, 1, 1, 0, 3'd6, 4'd0, 1, 3'd6, 0);
    step("rst_rand",  1, 0, 0, 0, 3'd0, 4'd0, 0, 3'd0, 0);
    m_st = 0; m_idx = '0; m_cnt = 0;
    for (int i = 0; i < 300; i++) rand_step();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
